// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types and width helpers for the kernel row-stream feed
package conv_pkg;

    typedef enum logic {
        SAME  = 1'b0,
        VALID = 1'b1
    } conv_mode_e;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } feed_state_e;

    function automatic int col_w(input int cols);
        return (cols > 1) ? $clog2(cols) : 1;
    endfunction

    // Row counter must also reach the PAD flush rows below the image.
    function automatic int row_w(input int rows, input int pad);
        return ((rows + pad) > 1) ? $clog2(rows + pad) : 1;
    endfunction

    function automatic conv_mode_e mode_decode(input logic [63:0] mode_str);
        return (mode_str == 64'("valid")) ? VALID : SAME;
    endfunction

endpackage

// File: rtl/line_ram.sv
// rtl/line_ram.sv - single-port read-first line buffer, one image row deep
module line_ram #(
    parameter int DEPTH  = 512,
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Asynchronous read returns the previous row's pixel before this edge's write.
    assign rdata = mem[addr];

endmodule

// File: rtl/kernel_line_feed.sv
// rtl/kernel_line_feed.sv - raster pixel stream to CONV_KERNEL_SIZE column-aligned row channels
module kernel_line_feed
    import conv_pkg::*;
#(
    parameter int IMAGE_COLUMN     = 512,
    parameter int IMAGE_ROW        = 512,
    parameter int IMAGE_DATA_WIDTH = 8,
    parameter int CONV_KERNEL_SIZE = 11,
    parameter int PAD              = (CONV_KERNEL_SIZE - 1) / 2,
    parameter     CONV_MODE        = "same"
) (
    input  logic                                             axi_clk,
    input  logic                                             axi_rst,
    input  logic                                             pix_valid,
    output logic                                             pix_ready,
    input  logic [IMAGE_DATA_WIDTH-1:0]                      pix_data,
    output logic [CONV_KERNEL_SIZE-1:0]                      shift_valid,
    output logic [CONV_KERNEL_SIZE-1:0][IMAGE_DATA_WIDTH-1:0] shift_data,
    output logic                                             frame_done
);

    localparam int         COL_W = col_w(IMAGE_COLUMN);
    localparam int         ROW_W = row_w(IMAGE_ROW, PAD);
    localparam conv_mode_e MODE  = mode_decode(64'(CONV_MODE));

    localparam logic [COL_W-1:0] COL_MAX         = COL_W'(IMAGE_COLUMN - 1);
    localparam logic [ROW_W-1:0] ROW_MAX         = ROW_W'(IMAGE_ROW - 1);
    localparam logic [ROW_W-1:0] FLUSH_ROW_MAX   = ROW_W'(IMAGE_ROW + PAD - 1);
    localparam logic [ROW_W-1:0] VALID_FIRST_ROW = ROW_W'(CONV_KERNEL_SIZE - 1);

    feed_state_e                state_q;
    feed_state_e                state_d;
    logic [COL_W-1:0]           col_q;
    logic [ROW_W-1:0]           row_q;
    logic                       advance;
    logic                       last_beat;
    logic                       col_last;
    logic                       beat_valid;
    logic [IMAGE_DATA_WIDTH-1:0] in_pix;
    logic [CONV_KERNEL_SIZE-1:0][IMAGE_DATA_WIDTH-1:0] ch_d;
    logic [IMAGE_DATA_WIDTH-1:0] ram_q [CONV_KERNEL_SIZE-1];

    assign pix_ready = (state_q == RUN);
    assign col_last  = (col_q == COL_MAX);

    always_comb begin
        state_d   = state_q;
        advance   = 1'b0;
        last_beat = 1'b0;
        in_pix    = '0;
        case (state_q)
            RUN: begin
                advance = pix_valid;
                in_pix  = pix_data;
                if (pix_valid && col_last && (row_q == ROW_MAX)) begin
                    if (MODE == SAME) begin
                        state_d = FLUSH;
                    end else begin
                        last_beat = 1'b1;
                    end
                end
            end
            FLUSH: begin
                // Flush beats push zero pixels so the cascade drains like real rows.
                advance = 1'b1;
                if (col_last && (row_q == FLUSH_ROW_MAX)) begin
                    last_beat = 1'b1;
                    state_d   = RUN;
                end
            end
            default: ;
        endcase
    end

    assign beat_valid = (MODE == SAME) || (row_q >= VALID_FIRST_ROW);

    always_comb begin
        ch_d    = '0;
        ch_d[0] = in_pix;
        for (int i = 1; i < CONV_KERNEL_SIZE; i++) begin
            // Rows above the frame top are zero; this also masks stale RAM data.
            ch_d[i] = (row_q < ROW_W'(i)) ? '0 : ram_q[i-1];
        end
    end

    for (genvar j = 0; j < CONV_KERNEL_SIZE - 1; j++) begin : g_line
        logic [IMAGE_DATA_WIDTH-1:0] wdata;
        if (j == 0) begin : g_head
            assign wdata = in_pix;
        end else begin : g_tail
            assign wdata = ram_q[j-1];
        end
        line_ram #(
            .DEPTH  (IMAGE_COLUMN),
            .WIDTH  (IMAGE_DATA_WIDTH),
            .ADDR_W (COL_W)
        ) u_ram (
            .clk   (axi_clk),
            .we    (advance),
            .addr  (col_q),
            .wdata (wdata),
            .rdata (ram_q[j])
        );
    end

    always_ff @(posedge axi_clk) begin
        if (axi_rst) begin
            state_q <= RUN;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            if (advance) begin
                if (col_last) begin
                    col_q <= '0;
                    row_q <= last_beat ? '0 : row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge axi_clk) begin
        if (axi_rst) begin
            shift_valid <= '0;
            shift_data  <= '0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= last_beat;
            if (advance) begin
                shift_valid <= beat_valid ? '1 : '0;
                shift_data  <= ch_d;
            end else begin
                shift_valid <= '0;
            end
        end
    end

endmodule

// File: tb/tb_kernel_line_feed.sv
// tb/tb_kernel_line_feed.sv - randomized bench for kernel_line_feed in same and valid modes
module tb_kernel_line_feed;

    localparam int K   = 3;
    localparam int PAD = 1;
    localparam int COL = 4;
    localparam int ROW = 3;
    localparam int W   = 8;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                s_pv = 1'b0, v_pv = 1'b0;
    logic [W-1:0]        s_pd = '0, v_pd = '0;
    logic                s_pr, v_pr;
    logic [K-1:0]        s_sv, v_sv;
    logic [K-1:0][W-1:0] s_sd, v_sd;
    logic                s_fd, v_fd;

    always #5 clk = ~clk;

    kernel_line_feed #(
        .IMAGE_COLUMN(COL), .IMAGE_ROW(ROW), .IMAGE_DATA_WIDTH(W),
        .CONV_KERNEL_SIZE(K), .PAD(PAD), .CONV_MODE("same")
    ) u_same (
        .axi_clk(clk), .axi_rst(rst), .pix_valid(s_pv), .pix_ready(s_pr),
        .pix_data(s_pd), .shift_valid(s_sv), .shift_data(s_sd), .frame_done(s_fd)
    );

    kernel_line_feed #(
        .IMAGE_COLUMN(COL), .IMAGE_ROW(ROW), .IMAGE_DATA_WIDTH(W),
        .CONV_KERNEL_SIZE(K), .PAD(PAD), .CONV_MODE("valid")
    ) u_valid (
        .axi_clk(clk), .axi_rst(rst), .pix_valid(v_pv), .pix_ready(v_pr),
        .pix_data(v_pd), .shift_valid(v_sv), .shift_data(v_sd), .frame_done(v_fd)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model, index 0 = same mode, 1 = valid mode.
    int                  mr [2];
    int                  mc [2];
    int                  fb [2];
    int                  frames [2];
    bit                  mfl [2];
    logic [K-1:0]        ev [2];
    logic [K-1:0][W-1:0] ed [2];
    bit                  edn [2];
    logic [W-1:0]        img [2][ROW][COL];
    int                  vcnt = 0;
    bit                  started = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input int m, input bit v, input logic [W-1:0] d, input bit r);
        int f;
        int c;
        if (r) begin
            mr[m] = 0; mc[m] = 0; fb[m] = 0; mfl[m] = 1'b0;
            ev[m] = '0; ed[m] = '0; edn[m] = 1'b0;
            return;
        end
        edn[m] = 1'b0;
        if (mfl[m]) begin
            f = fb[m] / COL + 1;
            c = fb[m] % COL;
            for (int i = 0; i < K; i++)
                ed[m][i] = (i < f) ? '0 : img[m][ROW-1-(i-f)][c];
            ev[m] = '1;
            fb[m]++;
            if (fb[m] == PAD * COL) begin
                mfl[m] = 1'b0; edn[m] = 1'b1; frames[m]++;
                mr[m] = 0; mc[m] = 0;
            end
        end else if (v) begin
            img[m][mr[m]][mc[m]] = d;
            for (int i = 0; i < K; i++)
                ed[m][i] = (mr[m] - i >= 0) ? img[m][mr[m]-i][mc[m]] : '0;
            ev[m] = (m == 0 || mr[m] >= K - 1) ? '1 : '0;
            if (mc[m] == COL - 1) begin
                mc[m] = 0;
                if (mr[m] == ROW - 1) begin
                    mr[m] = 0;
                    if (m == 0) begin
                        mfl[m] = 1'b1; fb[m] = 0;
                    end else begin
                        edn[m] = 1'b1; frames[m]++;
                    end
                end else begin
                    mr[m]++;
                end
            end else begin
                mc[m]++;
            end
        end else begin
            ev[m] = '0;
        end
    endtask

    function automatic logic [W-1:0] pixel_for(input int m);
        logic [W-1:0] base;
        if (frames[m] >= 2) return W'($urandom);
        base = (frames[m] == 1) ? 8'h80 : 8'h00;
        return base + W'(16 * mr[m] + mc[m]);
    endfunction

    // Called on a negedge; drives one cycle, then checks both DUTs after the edge.
    task automatic cycle(input bit vin, input bit rin);
        logic [W-1:0] d0;
        logic [W-1:0] d1;
        bit           s_acc;
        d0 = pixel_for(0);
        d1 = pixel_for(1);
        rst = rin; s_pv = vin; v_pv = vin; s_pd = d0; v_pd = d1;
        s_acc = vin && !mfl[0];
        #1;
        if (started) begin
            check("same_pix_ready", 32'(s_pr), 32'(!mfl[0]));
            check("valid_pix_ready", 32'(v_pr), 32'(1'b1));
        end
        started = 1'b1;
        @(posedge clk);
        #1;
        model_step(0, s_acc, d0, rin);
        model_step(1, vin, d1, rin);
        check("same_shift_valid", 32'(s_sv), 32'(ev[0]));
        check("same_shift_data", 32'(s_sd), 32'(ed[0]));
        check("same_frame_done", 32'(s_fd), 32'(edn[0]));
        check("valid_shift_valid", 32'(v_sv), 32'(ev[1]));
        check("valid_shift_data", 32'(v_sd), 32'(ed[1]));
        check("valid_frame_done", 32'(v_fd), 32'(edn[1]));
        if (rin) begin
            vcnt = 0;
        end else begin
            if (v_sv != '0) vcnt++;
            if (edn[1]) begin
                check("valid_beats_per_frame", 32'(vcnt), 32'(COL * (ROW - K + 1)));
                vcnt = 0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        bit vin;
        bit rin;
        bit rst_row_done;
        bit rst_flush_done;
        rst_row_done = 1'b0;
        rst_flush_done = 1'b0;
        for (int m = 0; m < 2; m++) begin
            frames[m] = 0;
            for (int r = 0; r < ROW; r++)
                for (int c = 0; c < COL; c++)
                    img[m][r][c] = '0;
        end
        @(negedge clk);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);
        repeat (40) cycle(1'b1, 1'b0);
        for (int n = 0; n < 500; n++) begin
            vin = ($urandom_range(0, 9) < 7);
            rin = 1'b0;
            if (!rst_row_done && !mfl[0] && mr[0] == 1 && mc[0] == 2) begin
                rin = 1'b1; rst_row_done = 1'b1;
            end else if (!rst_flush_done && mfl[0] && fb[0] == 1) begin
                rin = 1'b1; rst_flush_done = 1'b1;
            end
            cycle(vin, rin);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
